mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
Parametrised single-port data/instruction memory with a request/ready handshake, programmable wait states, per-byte write enables and out-of-range address detection. It sits between the processor datapath and the memory array. The handshake lets the control unit stall for slower memory; WAIT_STATES sets that memory latency. One outstanding access at a time; no queuing.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
ADDR_WIDTH, 16, address width in bits; word-addressed
DEPTH, 4096, number of words; valid addresses are 0..DEPTH-1
WAIT_STATES, 1, extra cycles inserted before the array access; legal range 0..7

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
Request  in  1  access request; sampled only in IDLE
MemWrite  in  1  1 = write, 0 = read; sampled with Request
ByteEnable  in  DATA_WIDTH/8  write lane enables; bit i covers bits [8i+7:8i]
Address  in  ADDR_WIDTH  word address; sampled with Request
DataIn  in  DATA_WIDTH  write data; sampled with Request
MemVal  out  DATA_WIDTH  read data; registered; holds until the next completed read
Ready  out  1  one-cycle completion pulse
Busy  out  1  high while an accepted access is in progress
AddrError  out  1  valid only while Ready=1; 1 = address was >= DEPTH

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; MemVal=0; Ready=0; Busy=0; AddrError=0; wait counter=0. Array contents are not cleared. Reset during WAIT or ACCESS aborts the access: no write occurs and no Ready pulse is produced.
- FSM states: IDLE, WAIT, ACCESS. Busy = (state != IDLE), decoded from registered state.
- IDLE: on an edge with Request=1, latch Address, DataIn, MemWrite and ByteEnable. Go to WAIT with counter=WAIT_STATES, or straight to ACCESS if WAIT_STATES=0. If Request=0, stay in IDLE.
- WAIT: decrement the counter each edge. At the edge where the counter equals 1, go to ACCESS.
- ACCESS: at the next edge, perform the array operation using the latched values, set Ready=1 for exactly one cycle, and return to IDLE.
- Latency: request accepted at edge N gives Ready=1 in the cycle after edge N+1+WAIT_STATES. Example: WAIT_STATES=1 gives a Ready pulse 3 cycles after acceptance.
- Back-to-back: the Ready cycle is in IDLE, so a Request held high is accepted on the edge that ends the Ready cycle. Sustained throughput is one access per WAIT_STATES+2 cycles.
- Request while Busy=1 is ignored, not queued. Inputs changing after acceptance have no effect on the access.
- Write: only lanes with ByteEnable[i]=1 are updated. ByteEnable=0 is a legal no-op that still produces Ready. A write does not change MemVal.
- Read: returns the full word and ignores ByteEnable. MemVal updates on the ACCESS edge, so new data is visible in the same cycle as Ready.
- Out-of-range (latched Address >= DEPTH): no array read or write occurs. AddrError=1 during the Ready cycle. For reads, MemVal is set to 0. AddrError=0 in every cycle where Ready=0.
- Read-after-write to the same address on consecutive requests returns the newly written data. No bypass path is needed, because accesses are serialised.
- Array: DEPTH entries, each DATA_WIDTH bits, index width ceil(log2(DEPTH)). The array is not reset.

Test Plan:
- Reset: assert reset for 2 cycles mid-stream -> MemVal=0, Ready=0, Busy=0, AddrError=0 on the cycle after; Busy stays low until a new Request.
- Write then read, WAIT_STATES=1: write 0xBEEF to address 0x0010 with ByteEnable=2'b11, then read 0x0010 -> each Ready pulse appears 3 cycles after acceptance; the read gives MemVal=0xBEEF, AddrError=0.
- Byte lanes: preload 0x1234 at address 5, write 0xABCD with ByteEnable=2'b10, read address 5 -> MemVal=0xAB34. ByteEnable=2'b00 write -> still reads 0xAB34.
- Out of range, DEPTH=4096: read address 0x1000 -> Ready with AddrError=1, MemVal=0. Write 0xFFFF to 0x1000, then read 0x0000 -> earlier content unchanged.
- Busy/back-to-back, WAIT_STATES=0: hold Request=1 with reads of addresses 1,2,3 -> Ready every 2 cycles; a Request pulse during Busy is dropped (exactly 3 Ready pulses total).
- Reset mid-write: accept a write of 0x5555 to address 7 (WAIT_STATES=3), then assert reset during WAIT -> no Ready; a later read of address 7 returns its prior value.

Source files
------------

// File: rtl/mem_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_controller_if
//  Description : Request/ready bus between the processor datapath and the
//                memory controller.
//                master : Request, MemWrite, ByteEnable, Address, DataIn (out)
//                         MemVal, Ready, Busy, AddrError              (in)
//                slave  : the mirror image of master
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                      Request;
  logic                      MemWrite;
  logic [DATA_WIDTH/8-1:0]   ByteEnable;
  logic [ADDR_WIDTH-1:0]     Address;
  logic [DATA_WIDTH-1:0]     DataIn;
  logic [DATA_WIDTH-1:0]     MemVal;
  logic                      Ready;
  logic                      Busy;
  logic                      AddrError;

  modport master (
    output Request, MemWrite, ByteEnable, Address, DataIn,
    input  MemVal, Ready, Busy, AddrError
  );

  modport slave (
    input  Request, MemWrite, ByteEnable, Address, DataIn,
    output MemVal, Ready, Busy, AddrError
  );
endinterface
`default_nettype wire

// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mem_controller
//  Description : Single-port word-addressed memory with a request/ready
//                handshake, programmable wait states, per-byte write enables
//                and out-of-range address detection. One access at a time.
//  Ports       : clock  - system clock, rising edge
//                reset  - synchronous active-high reset
//                bus    - mem_controller_if.slave (request in, response out)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  wire logic         clock,
  input  wire logic         reset,
  mem_controller_if.slave   bus
);

  localparam int c_LANES = DATA_WIDTH / 8;
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] c_DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [2:0] c_WAIT_INIT = 3'(WAIT_STATES);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_WAIT   = 2'd1;
  localparam logic [1:0] c_ST_ACCESS = 2'd2;

  logic [1:0]             r_state;
  logic [2:0]             r_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_we;
  logic [c_LANES-1:0]     r_be;
  logic [DATA_WIDTH-1:0]  r_memval;
  logic                   r_ready;
  logic                   r_addr_err;

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

  logic                   w_in_range;
  logic [c_IDX_W-1:0]     w_idx;
  logic                   w_do_write;

  assign w_in_range = ({1'b0, r_addr} < c_DEPTH_LIM);
  assign w_idx      = r_addr[c_IDX_W-1:0];
  assign w_do_write = (r_state == c_ST_ACCESS) && r_we && w_in_range && !reset;

  // Control path and registered read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_ST_IDLE;
      r_cnt      <= 3'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_memval   <= '0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      // Ready and AddrError are single-cycle pulses.
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (bus.Request) begin
            r_addr <= bus.Address;
            r_data <= bus.DataIn;
            r_we   <= bus.MemWrite;
            r_be   <= bus.ByteEnable;
            if (WAIT_STATES == 0) begin
              r_state <= c_ST_ACCESS;
            end else begin
              r_state <= c_ST_WAIT;
              r_cnt   <= c_WAIT_INIT;
            end
          end
        end
        c_ST_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= c_ST_ACCESS;
          end
        end
        c_ST_ACCESS: begin
          r_ready    <= 1'b1;
          r_addr_err <= !w_in_range;
          // Writes leave MemVal untouched; bad-address reads return zero.
          if (!r_we) begin
            r_memval <= w_in_range ? r_mem[w_idx] : '0;
          end
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Array write port; the array itself is never reset.
  always_ff @(posedge clock) begin
    if (w_do_write) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.MemVal    = r_memval;
  assign bus.Ready     = r_ready;
  assign bus.AddrError = r_addr_err;
  assign bus.Busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_controller
//  Description : Self-checking bench for mem_controller. Three instances with
//                WAIT_STATES = 1, 0 and 3. Stimulus pushes expected responses
//                into per-instance queues; monitors pop on each Ready pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_controller;

  typedef struct {
    int          ready_cyc;
    logic [15:0] mv;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  int   pulses1 = 0;

  logic        req  [3];
  logic        we   [3];
  logic [1:0]  be   [3];
  logic [15:0] addr [3];
  logic [15:0] din  [3];
  logic [15:0] last_mv [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_controller_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if0 ();
  mem_controller_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if1 ();
  mem_controller_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if2 ();

  assign if0.Request = req[0];  assign if0.MemWrite = we[0];  assign if0.ByteEnable = be[0];
  assign if0.Address = addr[0]; assign if0.DataIn   = din[0];
  assign if1.Request = req[1];  assign if1.MemWrite = we[1];  assign if1.ByteEnable = be[1];
  assign if1.Address = addr[1]; assign if1.DataIn   = din[1];
  assign if2.Request = req[2];  assign if2.MemWrite = we[2];  assign if2.ByteEnable = be[2];
  assign if2.Address = addr[2]; assign if2.DataIn   = din[2];

  mem_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(4096), .WAIT_STATES(1)) u_dut_ws1 (
    .clock(clock), .reset(reset), .bus(if0));
  mem_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(4096), .WAIT_STATES(0)) u_dut_ws0 (
    .clock(clock), .reset(reset), .bus(if1));
  mem_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(4096), .WAIT_STATES(3)) u_dut_ws3 (
    .clock(clock), .reset(reset), .bus(if2));

  function automatic int ws_of(input int d);
    case (d)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void push_q(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop_q(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void clear_q(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Monitor body shared by the three instances.
  function automatic void mon(input int d, input logic rdy, input logic aerr, input logic [15:0] mv);
    exp_t e;
    if (rdy) begin
      if (qsize(d) == 0) begin
        chk($sformatf("dut%0d_unexpected_ready", d), 32'd1, 32'd0);
      end else begin
        e = pop_q(d);
        chk($sformatf("dut%0d_latency", d), cyc, e.ready_cyc);
        chk($sformatf("dut%0d_memval", d), {16'h0, mv}, {16'h0, e.mv});
        chk($sformatf("dut%0d_addr_error", d), {31'h0, aerr}, {31'h0, e.err});
      end
    end else begin
      chk($sformatf("dut%0d_addr_error_idle", d), {31'h0, aerr}, 32'd0);
    end
  endfunction

  always @(negedge clock) if (!reset) mon(0, if0.Ready, if0.AddrError, if0.MemVal);
  always @(negedge clock) if (!reset) mon(1, if1.Ready, if1.AddrError, if1.MemVal);
  always @(negedge clock) if (!reset) mon(2, if2.Ready, if2.AddrError, if2.MemVal);
  always @(negedge clock) if (if1.Ready) pulses1 <= pulses1 + 1;

  // Expected entry for a request whose Request is raised at the current negedge.
  task automatic expect_op(input int d, input logic w, input logic [15:0] exp_mv, input logic exp_err);
    exp_t e;
    e.ready_cyc = cyc + 2 + ws_of(d);
    e.mv        = w ? last_mv[d] : exp_mv;
    e.err       = exp_err;
    if (!w) last_mv[d] = exp_mv;
    push_q(d, e);
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (qsize(d) != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (qsize(d) != 0) begin
      chk($sformatf("dut%0d_ready_timeout", d), 32'd0, 32'd1);
      clear_q(d);
    end
  endtask

  task automatic op(input int d, input logic w, input logic [1:0] b, input logic [15:0] a,
                    input logic [15:0] data, input logic [15:0] exp_mv, input logic exp_err);
    @(negedge clock);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; din[d] = data;
    expect_op(d, w, exp_mv, exp_err);
    @(negedge clock);
    req[d] = 1'b0;
    drain(d);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 2'b00; addr[i] = 16'h0; din[i] = 16'h0;
      last_mv[i] = 16'h0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_memval",  {16'h0, if0.MemVal}, 32'h0);
    chk("rst_ready",   {31'h0, if0.Ready}, 32'h0);
    chk("rst_busy",    {31'h0, if0.Busy}, 32'h0);
    chk("rst_addrerr", {31'h0, if0.AddrError}, 32'h0);

    // WAIT_STATES = 1: write/read, byte lanes, boundaries, out of range.
    op(0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    op(0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    op(0, 1'b1, 2'b11, 16'h0005, 16'h1234, 16'h0000, 1'b0);
    op(0, 1'b1, 2'b10, 16'h0005, 16'hABCD, 16'h0000, 1'b0);
    op(0, 1'b0, 2'b01, 16'h0005, 16'h0000, 16'hAB34, 1'b0);
    op(0, 1'b1, 2'b00, 16'h0005, 16'hFFFF, 16'h0000, 1'b0);
    op(0, 1'b0, 2'b11, 16'h0005, 16'h0000, 16'hAB34, 1'b0);
    op(0, 1'b1, 2'b11, 16'h0000, 16'h0042, 16'h0000, 1'b0);
    op(0, 1'b1, 2'b11, 16'h0FFF, 16'h7E57, 16'h0000, 1'b0);
    op(0, 1'b0, 2'b11, 16'h0FFF, 16'h0000, 16'h7E57, 1'b0);
    op(0, 1'b0, 2'b11, 16'h1000, 16'h0000, 16'h0000, 1'b1);
    op(0, 1'b1, 2'b11, 16'h1000, 16'hFFFF, 16'h0000, 1'b1);
    op(0, 1'b0, 2'b11, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    op(0, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h0042, 1'b0);

    // A write request raised while the read is in ACCESS must be dropped.
    @(negedge clock);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 2'b11; addr[0] = 16'h0010;
    expect_op(0, 1'b0, 16'hBEEF, 1'b0);
    @(negedge clock);
    req[0] = 1'b0;
    chk("busy_in_wait", {31'h0, if0.Busy}, 32'h1);
    @(negedge clock);
    req[0] = 1'b1; we[0] = 1'b1; din[0] = 16'h0000;
    @(negedge clock);
    req[0] = 1'b0;
    drain(0);
    @(negedge clock);
    chk("busy_after_drop", {31'h0, if0.Busy}, 32'h0);
    op(0, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

    // WAIT_STATES = 0: preload then back-to-back reads with Request held.
    op(1, 1'b1, 2'b11, 16'h0001, 16'h0101, 16'h0000, 1'b0);
    op(1, 1'b1, 2'b11, 16'h0002, 16'h0202, 16'h0000, 1'b0);
    op(1, 1'b1, 2'b11, 16'h0003, 16'h0303, 16'h0000, 1'b0);
    @(negedge clock);
    p0 = pulses1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001;
    expect_op(1, 1'b0, 16'h0101, 1'b0);
    @(negedge clock);
    addr[1] = 16'h0003; din[1] = 16'hDEAD; we[1] = 1'b1;
    @(negedge clock);
    addr[1] = 16'h0002; we[1] = 1'b0;
    expect_op(1, 1'b0, 16'h0202, 1'b0);
    @(negedge clock);
    addr[1] = 16'h0001; we[1] = 1'b1;
    @(negedge clock);
    addr[1] = 16'h0003; we[1] = 1'b0;
    expect_op(1, 1'b0, 16'h0303, 1'b0);
    @(negedge clock);
    req[1] = 1'b0;
    drain(1);
    repeat (6) @(negedge clock);
    chk("b2b_pulse_count", pulses1 - p0, 32'd3);
    op(1, 1'b0, 2'b11, 16'h0003, 16'h0000, 16'h0303, 1'b0);

    // WAIT_STATES = 3: known content at address 7.
    op(2, 1'b1, 2'b11, 16'h0007, 16'h1111, 16'h0000, 1'b0);
    op(2, 1'b0, 2'b11, 16'h0007, 16'h0000, 16'h1111, 1'b0);

    // Reset mid-access on two instances: no Ready, no write.
    @(negedge clock);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 2'b11; addr[2] = 16'h0007; din[2] = 16'h5555;
    @(negedge clock);
    req[0] = 1'b0; req[2] = 1'b0;
    chk("ws3_busy_before_reset", {31'h0, if2.Busy}, 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) last_mv[i] = 16'h0;
    chk("midrst_memval",  {16'h0, if0.MemVal}, 32'h0);
    chk("midrst_ready",   {31'h0, if0.Ready}, 32'h0);
    chk("midrst_busy",    {31'h0, if0.Busy}, 32'h0);
    chk("midrst_addrerr", {31'h0, if0.AddrError}, 32'h0);
    chk("midrst_ws3_busy", {31'h0, if2.Busy}, 32'h0);
    repeat (6) begin
      @(negedge clock);
      chk("post_rst_busy_ws1", {31'h0, if0.Busy}, 32'h0);
      chk("post_rst_busy_ws3", {31'h0, if2.Busy}, 32'h0);
    end
    op(2, 1'b0, 2'b11, 16'h0007, 16'h0000, 16'h1111, 1'b0);
    op(0, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
